// File: rtl/m20k_pkg.sv
// Shared constants, width helpers and transpose FSM states for the M20K model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package m20k_pkg;

    localparam int PHYS_ROWS = 128;
    localparam int PHYS_COLS = 160;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } xp_state_t;

    // Logical widths that tile a 160-bit row exactly
    function automatic bit legal_width(input int w);
        case (w)
            1, 2, 4, 5, 8, 10, 16, 20, 32, 40: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic int words_per_row(input int w, input int cols);
        return cols / w;
    endfunction

endpackage

// File: rtl/m20k_xpose_buf.sv
// Square bit tile: whole-word row writes, one column read out by index.
// Latency: write lands on the clock edge; column read is combinational.
// Backpressure: none; the owning FSM sequences writes and reads.
module m20k_xpose_buf #(
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [IW-1:0] rd_col,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] rows [W];

    // Capture one tile word per write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_idx] <= wr_data;
        end
    end

    // Column j: bit i comes from bit j of tile word i
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < W; i++) begin
            rd_data[i] = rows[i][rd_col];
        end
    end

endmodule

// File: rtl/m20k_bram_tdp_xpose.sv
// True dual-port M20K model on a 128x160 bit array plus a column-wise tile transpose reader.
// Latency: word reads 2 cycles (3 with M20K_OUT_REG_EN defined); tile beats follow a DATA_WIDTH+1 cycle fill.
// Backpressure: port B drops requests while b_ready is low (fill); tile beats hold until xp_out_ready.
module m20k_bram_tdp_xpose #(
    parameter int DATA_WIDTH = 8,
    parameter int PHYS_ROWS  = m20k_pkg::PHYS_ROWS,
    parameter int PHYS_COLS  = m20k_pkg::PHYS_COLS,
    localparam int DEPTH     = PHYS_ROWS * PHYS_COLS / DATA_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  a_wen,
    input  logic                  a_ren,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic                  b_wen,
    input  logic                  b_ren,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  b_ready,
    input  logic                  xp_req_valid,
    output logic                  xp_req_ready,
    input  logic [AW-1:0]         xp_base,
    output logic                  xp_out_valid,
    input  logic                  xp_out_ready,
    output logic [DATA_WIDTH-1:0] xp_out_data,
    output logic                  xp_out_last,
    output logic                  xp_err,
    output logic                  collision
);
    import m20k_pkg::*;

    localparam int WPR = words_per_row(DATA_WIDTH, PHYS_COLS);
    localparam int RW  = $clog2(PHYS_ROWS);
    localparam int CW  = $clog2(PHYS_COLS);
    localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int JW  = $clog2(DATA_WIDTH + 1);

    if (!legal_width(DATA_WIDTH)) begin : g_bad_width
        $error("m20k_bram_tdp_xpose: DATA_WIDTH %0d is not a legal M20K width", DATA_WIDTH);
    end

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] addr);
        return RW'(addr / AW'(WPR));
    endfunction

    function automatic logic [CW-1:0] col_of(input logic [AW-1:0] addr);
        return CW'((addr % AW'(WPR)) * AW'(DATA_WIDTH));
    endfunction

    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    // Bit-cell array: retained across reset, zero only at power-up
    logic [PHYS_COLS-1:0] mem [PHYS_ROWS] = '{default: '0};

    // Request stage
    logic [AW-1:0]         a_addr_q, b_addr_q;
    logic [DATA_WIDTH-1:0] a_wdata_q, b_wdata_q;
    logic                  a_wen_q, a_ren_q, b_wen_q, b_ren_q;
    logic                  xp_rd_q;
    logic [IW-1:0]         xp_idx_q;

    // Array access stage
    logic [DATA_WIDTH-1:0] a_rd_r, b_rd_r;
    logic                  a_rv_r, b_rv_r;
    logic [DATA_WIDTH-1:0] a_word, b_word;
    logic                  a_in, b_in;

    // Transpose FSM
    xp_state_t             state_q, state_d;
    logic [JW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         base_q, base_d;
    logic                  err_d, err_q;
    logic                  fill_rd;
    logic                  tile_bad;
    logic [AW-1:0]         fill_addr;
    logic [DATA_WIDTH-1:0] col_data;

    assign a_in      = in_range(a_addr_q);
    assign b_in      = in_range(b_addr_q);
    assign a_word    = mem[row_of(a_addr_q)][col_of(a_addr_q) +: DATA_WIDTH];
    assign b_word    = mem[row_of(b_addr_q)][col_of(b_addr_q) +: DATA_WIDTH];
    assign tile_bad  = ((int'(xp_base) % DATA_WIDTH) != 0) ||
                       ((int'(xp_base) + DATA_WIDTH) > DEPTH);
    assign fill_addr = base_q + AW'(cnt_q);

    // Register requests; during fill, port B's slot carries the internal tile reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_addr_q  <= '0;
            a_wdata_q <= '0;
            a_wen_q   <= 1'b0;
            a_ren_q   <= 1'b0;
            b_addr_q  <= '0;
            b_wdata_q <= '0;
            b_wen_q   <= 1'b0;
            b_ren_q   <= 1'b0;
            xp_rd_q   <= 1'b0;
            xp_idx_q  <= '0;
        end else begin
            a_addr_q  <= a_addr;
            a_wdata_q <= a_wdata;
            a_wen_q   <= a_wen;
            a_ren_q   <= a_ren;
            b_wdata_q <= b_wdata;
            xp_idx_q  <= IW'(cnt_q);
            if (state_q == FILL) begin
                b_addr_q <= fill_addr;
                b_wen_q  <= 1'b0;
                b_ren_q  <= 1'b0;
                xp_rd_q  <= fill_rd;
            end else begin
                b_addr_q <= b_addr;
                b_wen_q  <= b_wen;
                b_ren_q  <= b_ren;
                xp_rd_q  <= 1'b0;
            end
        end
    end

    // Array writes; port A is applied last so it wins a same-word conflict
    always_ff @(posedge clk) begin
        if (b_wen_q && b_in) begin
            mem[row_of(b_addr_q)][col_of(b_addr_q) +: DATA_WIDTH] <= b_wdata_q;
        end
        if (a_wen_q && a_in) begin
            mem[row_of(a_addr_q)][col_of(a_addr_q) +: DATA_WIDTH] <= a_wdata_q;
        end
    end

    // Read-first capture of both ports plus the same-word write conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_r    <= '0;
            a_rv_r    <= 1'b0;
            b_rd_r    <= '0;
            b_rv_r    <= 1'b0;
            collision <= 1'b0;
        end else begin
            a_rv_r    <= a_ren_q;
            b_rv_r    <= b_ren_q;
            collision <= a_wen_q && b_wen_q && a_in && (a_addr_q == b_addr_q);
            if (a_ren_q) begin
                a_rd_r <= a_in ? a_word : '0;
            end
            if (b_ren_q) begin
                b_rd_r <= b_in ? b_word : '0;
            end
        end
    end

`ifdef M20K_OUT_REG_EN
    // Extra output register stage on both read ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            a_rdata  <= a_rd_r;
            a_rvalid <= a_rv_r;
            b_rdata  <= b_rd_r;
            b_rvalid <= b_rv_r;
        end
    end
`else
    assign a_rdata  = a_rd_r;
    assign a_rvalid = a_rv_r;
    assign b_rdata  = b_rd_r;
    assign b_rvalid = b_rv_r;
`endif

    // Tile buffer snapshots each fill read as it leaves the array
    m20k_xpose_buf #(
        .W  (DATA_WIDTH),
        .IW (IW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (xp_rd_q),
        .wr_idx  (xp_idx_q),
        .wr_data (b_word),
        .rd_col  (IW'(cnt_q)),
        .rd_data (col_data)
    );

    // Transpose FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            err_q   <= err_d;
        end
    end

    // Transpose FSM next state and handshake outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        err_d        = 1'b0;
        fill_rd      = 1'b0;
        xp_req_ready = 1'b0;
        b_ready      = 1'b1;
        xp_out_valid = 1'b0;
        xp_out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                xp_req_ready = 1'b1;
                if (xp_req_valid) begin
                    base_d = xp_base;
                    if (tile_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
            end
            FILL: begin
                b_ready = 1'b0;
                // one extra cycle lets the last read drain into the buffer
                if (cnt_q == JW'(DATA_WIDTH)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    fill_rd = 1'b1;
                    cnt_d   = cnt_q + JW'(1);
                end
            end
            EMIT: begin
                xp_out_valid = 1'b1;
                xp_out_last  = (cnt_q == JW'(DATA_WIDTH - 1));
                if (xp_out_ready) begin
                    if (xp_out_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + JW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign xp_out_data = (state_q == EMIT) ? col_data : '0;
    assign xp_err      = err_q;

endmodule

// File: tb/tb_m20k_bram_tdp_xpose.sv
// Self-checking bench: directed collision/transpose cases plus random dual-port traffic.
// Latency: follows the 2-cycle read path (3 with M20K_OUT_REG_EN).
// Backpressure: exercises b_ready during fill and toggled xp_out_ready.
module tb_m20k_bram_tdp_xpose;

    localparam int DW    = 8;
    localparam int DEPTH = 2560;
    localparam int AW    = 12;
    localparam int NRAND = 400;
`ifdef M20K_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] a_addr = '0, b_addr = '0, xp_base = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_wen = 1'b0, a_ren = 1'b0, b_wen = 1'b0, b_ren = 1'b0;
    logic          xp_req_valid = 1'b0, xp_out_ready = 1'b0;
    logic [DW-1:0] a_rdata, b_rdata, xp_out_data;
    logic          a_rvalid, b_rvalid, b_ready, xp_req_ready;
    logic          xp_out_valid, xp_out_last, xp_err, collision;

    m20k_bram_tdp_xpose #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_wen        (a_wen),
        .a_ren        (a_ren),
        .a_rdata      (a_rdata),
        .a_rvalid     (a_rvalid),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_wen        (b_wen),
        .b_ren        (b_ren),
        .b_rdata      (b_rdata),
        .b_rvalid     (b_rvalid),
        .b_ready      (b_ready),
        .xp_req_valid (xp_req_valid),
        .xp_req_ready (xp_req_ready),
        .xp_base      (xp_base),
        .xp_out_valid (xp_out_valid),
        .xp_out_ready (xp_out_ready),
        .xp_out_data  (xp_out_data),
        .xp_out_last  (xp_out_last),
        .xp_err       (xp_err),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct packed {
        logic          av;
        logic [DW-1:0] ad;
        logic          bv;
        logic [DW-1:0] bd;
    } rexp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mread(input int addr);
        return (addr < DEPTH) ? ref_mem[addr] : '0;
    endfunction

    // Column j of a tile whose word i is tile[i]
    function automatic logic [DW-1:0] tcol(input logic [DW-1:0][DW-1:0] tile, input int j);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) r[i] = tile[i][j];
        return r;
    endfunction

    function automatic int pick_addr();
        if ($urandom_range(0, 9) == 0) return DEPTH + int'($urandom_range(0, 1535));
        return int'($urandom_range(0, 15));
    endfunction

    task automatic wr(input bit pb, input int addr, input logic [DW-1:0] d);
        if (pb) begin
            b_addr = AW'(addr); b_wdata = d; b_wen = 1'b1;
        end else begin
            a_addr = AW'(addr); a_wdata = d; a_wen = 1'b1;
        end
        step();
        a_wen = 1'b0;
        b_wen = 1'b0;
        if (addr < DEPTH) ref_mem[addr] = d;
    endtask

    task automatic rd(input bit pb, input int addr, input string tag);
        logic [DW-1:0] e;
        e = mread(addr);
        if (pb) begin b_addr = AW'(addr); b_ren = 1'b1; end
        else    begin a_addr = AW'(addr); a_ren = 1'b1; end
        step();
        a_ren = 1'b0;
        b_ren = 1'b0;
        repeat (LAT - 1) step();
        check({tag, "_vld"}, 32'(pb ? b_rvalid : a_rvalid), 32'd1);
        check(tag, 32'(pb ? b_rdata : a_rdata), 32'(e));
    endtask

    task automatic run_xpose(input int base, input bit toggle, input bit snap_wr, input string tag);
        logic [DW-1:0][DW-1:0] tile;
        logic [DW-1:0]         nv;
        int                    j, guard, b_pulses;
        bit                    rdy;
        for (int i = 0; i < DW; i++) tile[i] = ref_mem[base + i];
        nv = ~tile[0];
        check({tag, "_req_rdy"}, 32'(xp_req_ready), 32'd1);
        xp_base = AW'(base);
        xp_req_valid = 1'b1;
        step();
        xp_req_valid = 1'b0;
        check({tag, "_b_ready_fill"}, 32'(b_ready), 32'd0);
        // port A hits word 0 on the very edge it is snapshotted; port B traffic must be dropped
        if (snap_wr) begin
            a_addr = AW'(base); a_wdata = nv; a_wen = 1'b1;
        end
        b_addr = AW'(base + 1);
        b_ren = 1'b1;
        b_pulses = 0;
        guard = 0;
        while (!xp_out_valid && guard < 40) begin
            step();
            a_wen = 1'b0;
            if (b_rvalid) b_pulses++;
            guard++;
        end
        b_ren = 1'b0;
        if (snap_wr) ref_mem[base] = nv;
        check({tag, "_fill_timeout"}, 32'(guard < 40), 32'd1);
        j = 0;
        guard = 0;
        while (j < DW && guard < 100) begin
            rdy = toggle ? (guard % 2 == 0) : 1'b1;
            xp_out_ready = rdy;
            if (xp_out_valid) begin
                check({tag, "_beat"}, 32'(xp_out_data), 32'(tcol(tile, j)));
                check({tag, "_last"}, 32'(xp_out_last), 32'(j == DW - 1));
                if (rdy) j++;
            end
            step();
            if (b_rvalid) b_pulses++;
            guard++;
        end
        xp_out_ready = 1'b0;
        check({tag, "_beats"}, 32'(j), 32'(DW));
        check({tag, "_done_vld"}, 32'(xp_out_valid), 32'd0);
        check({tag, "_b_dropped"}, 32'(b_pulses), 32'd0);
        check({tag, "_idle_rdy"}, 32'(xp_req_ready), 32'd1);
    endtask

    task automatic xp_bad(input int base, input string tag);
        int beats;
        xp_base = AW'(base);
        xp_req_valid = 1'b1;
        step();
        xp_req_valid = 1'b0;
        check({tag, "_err"}, 32'(xp_err), 32'd1);
        beats = 0;
        step();
        check({tag, "_err_pulse"}, 32'(xp_err), 32'd0);
        repeat (20) begin
            if (xp_out_valid) beats++;
            step();
        end
        check({tag, "_no_beats"}, 32'(beats), 32'd0);
        check({tag, "_req_rdy"}, 32'(xp_req_ready), 32'd1);
    endtask

    initial begin
        rexp_t         e;
        logic          ce;
        int            aa, ba, guard, base;
        logic [DW-1:0] tile0 [DW];
        logic          cq [$];
        rexp_t         rq [$];

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset state
        repeat (3) step();
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_rdata", 32'(b_rdata), 32'd0);
        check("rst_xp_valid", 32'(xp_out_valid), 32'd0);
        check("rst_xp_err", 32'(xp_err), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_req_rdy", 32'(xp_req_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        rst = 1'b0;
        step();
        rd(1, 500, "init_zero");

        // A writes 100, B reads it after two idle cycles: exact latency
        wr(0, 100, 8'h5A);
        step();
        step();
        b_addr = AW'(100);
        b_ren = 1'b1;
        step();
        b_ren = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            check("lat_early_vld", 32'(b_rvalid), 32'd0);
            step();
        end
        check("lat_vld", 32'(b_rvalid), 32'd1);
        check("lat_data", 32'(b_rdata), 32'h5A);
        step();
        check("lat_pulse", 32'(b_rvalid), 32'd0);
        check("lat_hold", 32'(b_rdata), 32'h5A);

        // Same-word double write: A wins, collision pulses once
        a_addr = AW'(7); a_wdata = 8'h11; a_wen = 1'b1;
        b_addr = AW'(7); b_wdata = 8'h22; b_wen = 1'b1;
        step();
        a_wen = 1'b0;
        b_wen = 1'b0;
        ref_mem[7] = 8'h11;
        check("col_early", 32'(collision), 32'd0);
        step();
        check("col_pulse", 32'(collision), 32'd1);
        step();
        check("col_once", 32'(collision), 32'd0);
        rd(0, 7, "col_rd_a");
        rd(1, 7, "col_rd_b");

        // Different words of the same physical row both land, no collision
        a_addr = AW'(40); a_wdata = 8'hA4; a_wen = 1'b1;
        b_addr = AW'(41); b_wdata = 8'hB4; b_wen = 1'b1;
        step();
        a_wen = 1'b0;
        b_wen = 1'b0;
        ref_mem[40] = 8'hA4;
        ref_mem[41] = 8'hB4;
        step();
        check("row_share_col", 32'(collision), 32'd0);
        rd(0, 41, "row_share_41");
        rd(1, 40, "row_share_40");

        // Cross-port read-first, then same-port read-first
        wr(0, 9, 8'h33);
        a_addr = AW'(9); a_wdata = 8'h44; a_wen = 1'b1;
        b_addr = AW'(9); b_ren = 1'b1;
        step();
        a_wen = 1'b0;
        b_ren = 1'b0;
        repeat (LAT - 1) step();
        check("xport_old_vld", 32'(b_rvalid), 32'd1);
        check("xport_old", 32'(b_rdata), 32'h33);
        ref_mem[9] = 8'h44;
        rd(1, 9, "xport_new");
        a_addr = AW'(9); a_wdata = 8'h55; a_wen = 1'b1; a_ren = 1'b1;
        step();
        a_wen = 1'b0;
        a_ren = 1'b0;
        repeat (LAT - 1) step();
        check("sport_old", 32'(a_rdata), 32'h44);
        ref_mem[9] = 8'h55;
        rd(0, 9, "sport_new");

        // Out-of-range accesses: write ignored, read returns zero
        wr(1, DEPTH, 8'hEE);
        rd(0, 0, "oor_no_alias");
        rd(0, 3000, "oor_rd");

        // Identity tile, then the same tile under toggled ready
        for (int i = 0; i < DW; i++) wr(i % 2, 16 + i, DW'(1 << i));
        run_xpose(16, 1'b0, 1'b0, "xp_id");
        run_xpose(16, 1'b1, 1'b0, "xp_tog");
        xp_bad(17, "xp_bad17");
        xp_bad(DEPTH, "xp_bad_end");

        // Random tiles, including the last legal one, with a snapshot-racing write
        for (int t = 0; t < 2; t++) begin
            base = (t == 0) ? DEPTH - DW : 8 * int'($urandom_range(4, 318));
            for (int i = 0; i < DW; i++) wr(i % 2, base + i, DW'($urandom));
            run_xpose(base, t[0], 1'b1, "xp_rnd");
            rd(1, base, "xp_snap_after");
        end

        // Reset while beat 3 of a tile is presented
        for (int i = 0; i < DW; i++) tile0[i] = ref_mem[16 + i];
        xp_base = AW'(16);
        xp_req_valid = 1'b1;
        step();
        xp_req_valid = 1'b0;
        guard = 0;
        while (!xp_out_valid && guard < 40) begin
            step();
            guard++;
        end
        check("rst_mid_fill_timeout", 32'(guard < 40), 32'd1);
        xp_out_ready = 1'b1;
        repeat (3) step();
        check("rst_mid_beat3", 32'(xp_out_data), 32'(tile0[3]));
        rst = 1'b1;
        #1;
        check("rst_mid_vld_now", 32'(xp_out_valid), 32'd0);
        step();
        rst = 1'b0;
        xp_out_ready = 1'b0;
        step();
        check("rst_mid_req_rdy", 32'(xp_req_ready), 32'd1);
        guard = 0;
        repeat (12) begin
            if (xp_out_valid) guard++;
            step();
        end
        check("rst_mid_no_beats", 32'(guard), 32'd0);
        for (int i = 0; i < DW; i++) rd(i % 2, 16 + i, "rst_mid_intact");

        // Random dual-port traffic against the word-level model
        for (int c = 0; c < NRAND + LAT; c++) begin
            e = '0;
            ce = 1'b0;
            a_wen = 1'b0; a_ren = 1'b0; b_wen = 1'b0; b_ren = 1'b0;
            if (c < NRAND) begin
                aa = pick_addr();
                ba = pick_addr();
                a_addr = AW'(aa);
                b_addr = AW'(ba);
                a_wdata = DW'($urandom);
                b_wdata = DW'($urandom);
                a_wen = ($urandom_range(0, 2) == 0);
                b_wen = ($urandom_range(0, 2) == 0);
                a_ren = 1'($urandom_range(0, 1));
                b_ren = 1'($urandom_range(0, 1));
                e.av = a_ren;
                e.ad = mread(aa);
                e.bv = b_ren;
                e.bd = mread(ba);
                ce = a_wen && b_wen && (aa == ba) && (aa < DEPTH);
                if (b_wen && ba < DEPTH) ref_mem[ba] = b_wdata;
                if (a_wen && aa < DEPTH) ref_mem[aa] = a_wdata;
            end
            rq.push_back(e);
            cq.push_back(ce);
            step();
            if (cq.size() == 2) check("rnd_collision", 32'(collision), 32'(cq.pop_front()));
            if (rq.size() == LAT) begin
                e = rq.pop_front();
                check("rnd_a_vld", 32'(a_rvalid), 32'(e.av));
                check("rnd_b_vld", 32'(b_rvalid), 32'(e.bv));
                if (e.av) check("rnd_a_data", 32'(a_rdata), 32'(e.ad));
                if (e.bv) check("rnd_b_data", 32'(b_rdata), 32'(e.bd));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
